tile_bist: RTL
==============

Name: tile_bist

Overview:
- Built-in stimulus/response engine for one 8-in/8-out combinational microtile.
- Drives the tile's ui_in bus with a counter or LFSR pattern sequence.
- Waits a programmable settle time for each pattern, then compacts the tile's uo_out into a 16-bit MISR signature.
- Sits directly upstream of the tile, feeding ui_in, and downstream of it, consuming uo_out. Gives the bench or a top-level controller a single pass/fail per tile.

Parameters:
- PATTERN_COUNT, 256, number of patterns applied per run (1..256).
- SETTLE_CYCLES, 2, cycles each pattern is held before capture (>=1).
- LFSR_SEED, 8'h01, first pattern in LFSR mode (must be nonzero).
- MISR_SEED, 16'h0000, signature value at start of run.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  pulse; begins a run when idle or done.
- mode  in  1  0 = binary counter patterns, 1 = LFSR patterns; sampled on the start-accept edge.
- expected  in  16  golden signature; sampled on the final capture edge.
- ui_in_drv  out  8  drives tile ui_in.
- uo_out_in  in  8  tile uo_out (combinational function of ui_in_drv).
- busy  out  1  high in SETTLE/CAPTURE.
- done  out  1  high in DONE.
- pass  out  1  registered; valid when done=1.
- signature  out  16  current MISR value.

Behaviour:
- Reset (async, any state): state=IDLE; ui_in_drv=8'h00; signature=MISR_SEED; busy=0; done=0; pass=0.
- States: IDLE, SETTLE, CAPTURE, DONE.
- IDLE/DONE, start=1, on clock edge:
  - latch mode; signature<=MISR_SEED; pattern index<=0.
  - ui_in_drv<=first pattern (8'h00 in counter mode, LFSR_SEED in LFSR mode).
  - settle counter<=SETTLE_CYCLES; done<=0; pass<=0; go SETTLE.
- SETTLE: counter decrements each cycle; when it reaches 1, next state is CAPTURE. Pattern is therefore held SETTLE_CYCLES cycles before the capture cycle.
- CAPTURE (one cycle): on its closing edge, signature<=next MISR value using uo_out_in.
  - If index==PATTERN_COUNT-1: go DONE; ui_in_drv<=8'h00; pass<=(MISR next value == expected).
  - Else: index+1; ui_in_drv<=next pattern; counter reload; go SETTLE.
- Counter pattern: index[7:0].
- LFSR pattern: shift left, feedback bit0 = q[7]^q[5]^q[4]^q[3]. Maximal length 255; patterns repeat after 255 steps.
- MISR next value = {sig[14:0], sig[15]^sig[13]^sig[12]^sig[10]} XOR {8'h00, uo_out_in}.
- Timing: a run is exactly PATTERN_COUNT*(SETTLE_CYCLES+1) cycles, counted from the start-accept edge to the edge on which done rises.
- start while busy: ignored. Mode changes mid-run: ignored.
- start in DONE: clears done/pass on the accept edge and restarts the run.
- done and pass hold until the next accepted start or reset.
- Reset asserted mid-run: aborts immediately to reset values; no partial done.

Decomposition:
- Package tile_bist_pkg:
  - state enum.
  - SIG_W=16, PAT_W=8.
  - LFSR tap mask 8'hB8.
  - MISR feedback tap positions (15, 13, 12, 10).
  - LFSR_SEED and MISR_SEED default constants.
- Sub-module tile_bist_misr: 16-bit MISR with seed load and enable, shared with future multi-tile wrappers.
- Pattern generator stays inline.

Test Plan:
- Tile model uo=8'h00, defaults, mode=0, expected=16'h0000 -> after exactly 768 cycles done=1, signature=16'h0000, pass=1, ui_in_drv=8'h00.
- PATTERN_COUNT=2, SETTLE_CYCLES=1, uo=8'h01 constant -> signature 16'h0001 after first capture, 16'h0003 at done (cycle 4); expected=16'h0003 gives pass=1, expected=16'h0004 gives pass=0.
- PATTERN_COUNT=1, uo=8'h5A -> signature=16'h005A; ui_in_drv=8'h00 for counter mode, 8'h01 for LFSR mode during SETTLE.
- mode=1, identity tile (uo=ui), PATTERN_COUNT=4 -> ui_in_drv sequence 01,02,04,08, each held 3 cycles (1 settle cycle counted into CAPTURE); signature matches reference model.
- start pulsed at cycle 5 of a run -> ignored; done timing unchanged. Reset asserted at cycle 10 -> all outputs return to reset values asynchronously, before the next clock edge; next start runs cleanly.
- Back-to-back: start asserted on the cycle after done -> done falls, the new run completes with an identical signature.

Source files
------------

// File: rtl/tile_bist_pkg.sv
// Shared types and constants for the tile BIST engine: FSM states, widths,
// LFSR/MISR tap definitions and their next-state helpers.
package tile_bist_pkg;

    localparam int SIG_W = 16;
    localparam int PAT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_DONE
    } state_e;

    // Pattern LFSR taps at bits 7,5,4,3; MISR feedback taps at bits 15,13,12,10
    localparam logic [PAT_W-1:0] LFSR_TAPS = 8'hB8;
    localparam logic [SIG_W-1:0] MISR_TAPS = 16'hB400;

    localparam logic [PAT_W-1:0] LFSR_SEED_DFLT = 8'h01;
    localparam logic [SIG_W-1:0] MISR_SEED_DFLT = 16'h0000;

    function automatic logic [PAT_W-1:0] lfsr_next(input logic [PAT_W-1:0] q);
        return {q[PAT_W-2:0], ^(q & LFSR_TAPS)};
    endfunction

    function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] sig,
                                                   input logic [PAT_W-1:0] data);
        return {sig[SIG_W-2:0], ^(sig & MISR_TAPS)} ^ {{(SIG_W-PAT_W){1'b0}}, data};
    endfunction

endpackage

// File: rtl/tile_bist_misr.sv
// 16-bit multiple-input signature register with seed load and capture enable.
// Also exposes the would-be next value so callers can compare before it lands.
module tile_bist_misr
    import tile_bist_pkg::*;
#(
    parameter logic [SIG_W-1:0] SEED = MISR_SEED_DFLT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [PAT_W-1:0] data,
    output logic [SIG_W-1:0] sig,
    output logic [SIG_W-1:0] sig_nxt
);

    assign sig_nxt = misr_next(sig, data);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       sig <= SEED;
        else if (load) sig <= SEED;
        else if (en)   sig <= sig_nxt;
    end

endmodule

// File: rtl/tile_bist.sv
// Stimulus/response BIST for one 8-in/8-out combinational tile: drives counter
// or LFSR patterns, holds each for a settle window, compacts responses in a MISR.
module tile_bist
    import tile_bist_pkg::*;
#(
    parameter int               PATTERN_COUNT = 256,
    parameter int               SETTLE_CYCLES = 2,
    parameter logic [PAT_W-1:0] LFSR_SEED     = LFSR_SEED_DFLT,
    parameter logic [SIG_W-1:0] MISR_SEED     = MISR_SEED_DFLT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [SIG_W-1:0] expected,
    output logic [PAT_W-1:0] ui_in_drv,
    input  logic [PAT_W-1:0] uo_out_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature
);

    localparam int               CNT_W    = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES);
    localparam logic [PAT_W-1:0] LAST_IDX = PAT_W'(PATTERN_COUNT - 1);

    state_e           state, state_nxt;
    logic [PAT_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    logic             mode_q;
    logic             accept;
    logic             last;
    logic [PAT_W-1:0] pat_nxt;
    logic [SIG_W-1:0] sig_nxt;

    assign accept  = start && (state == ST_IDLE || state == ST_DONE);
    assign last    = (idx == LAST_IDX);
    // The driven pattern doubles as the LFSR state, so no separate shift register
    assign pat_nxt = mode_q ? lfsr_next(ui_in_drv) : PAT_W'(idx + 1'b1);
    assign busy    = (state == ST_SETTLE) || (state == ST_CAPTURE);
    assign done    = (state == ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: if (start) state_nxt = ST_SETTLE;
            ST_SETTLE:        if (cnt == CNT_W'(1)) state_nxt = ST_CAPTURE;
            ST_CAPTURE:       state_nxt = last ? ST_DONE : ST_SETTLE;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            cnt       <= '0;
            mode_q    <= 1'b0;
            ui_in_drv <= '0;
            pass      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        mode_q    <= mode;
                        idx       <= '0;
                        ui_in_drv <= mode ? LFSR_SEED : '0;
                        cnt       <= CNT_LOAD;
                        pass      <= 1'b0;
                    end
                end
                ST_SETTLE: cnt <= cnt - CNT_W'(1);
                ST_CAPTURE: begin
                    if (last) begin
                        ui_in_drv <= '0;
                        pass      <= (sig_nxt == expected);
                    end else begin
                        idx       <= idx + 1'b1;
                        ui_in_drv <= pat_nxt;
                        cnt       <= CNT_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

    tile_bist_misr #(.SEED(MISR_SEED)) u_misr (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .en      (state == ST_CAPTURE),
        .data    (uo_out_in),
        .sig     (signature),
        .sig_nxt (sig_nxt)
    );

endmodule
